dsi_fifo_wr_arb: RTL and testbench
==================================

# dsi_fifo_wr_arb

Round-robin write-port arbiter that shares one 256x32b prefetch sync FIFO between up to `N_REQ` pixel/command producers in the MIPI DSI colorbar pipeline. Each producer offers a valid/ready word stream framed into bursts. The arbiter grants one producer at a time, passes its words straight into the FIFO write port under FIFO back-pressure, and releases the grant at burst end or at the burst-length cap. It sits between the pattern/command generators and the FIFO feeding the DSI packetizer.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `DATA_W`, 32: word width; equals the FIFO write width.
- `BURST_LEN`, 16: maximum words per grant, 1..255.
- `IDLE_TIMEOUT`, 8: stall cycles before forced release, 1..255. Used only with `DSI_ARB_IDLE_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock. All logic rises on this edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in N_REQ: per-requester word valid.
- `req_data` in N_REQ*DATA_W: requester i occupies bits [i*DATA_W +: DATA_W].
- `req_last` in N_REQ: marks the final word of the current burst; qualified by valid.
- `req_ready` out N_REQ: word accepted when valid & ready.
- `fifo_wr_en` out 1: FIFO write strobe.
- `fifo_wr_data` out DATA_W: FIFO write data.
- `fifo_wr_vld` in 1: FIFO can accept a word this cycle (not full).
- `grant_id` out clog2(N_REQ): index of the current or most recent grantee.
- `busy` out 1: high while a grant is held.

## Operation
- States: IDLE and XFER.
- IDLE:
  - If any `req_valid` is high, select the first requester at or after `rr_ptr`, searching upward and wrapping modulo N_REQ.
  - Register it into `grant_id`, clear `beat_cnt`, and move to XFER.
  - If no request is present, stay in IDLE.
- XFER:
  - `req_ready[grant_id] = fifo_wr_vld`; all other ready bits are 0.
  - `fifo_wr_en = req_valid[grant_id] & fifo_wr_vld`.
  - `fifo_wr_data = req_data[grant_id]`, combinational mux.
  - Each accepted word increments `beat_cnt`. The counter is clog2(BURST_LEN+1) bits wide and never wraps.
- End of grant: the first accepted word that has `req_last` set, or the word that makes `beat_cnt == BURST_LEN`, whichever comes first.
  - Next state is IDLE.
  - `rr_ptr = grant_id + 1` mod N_REQ.
- If a burst hits the cap without `req_last`, the requester keeps its place in the stream. Its remaining words continue under a later grant; no words are dropped or duplicated.
- Outside XFER: `fifo_wr_en = 0`, `req_ready = 0`, `fifo_wr_data = 0`.
- `busy = (state == XFER)`.
- A deasserted `req_valid` inside XFER is a stall, not a release. The grant holds (see Configuration).
- FIFO full (`fifo_wr_vld = 0`): nothing is accepted, `beat_cnt` holds, and the grant holds.
- Simultaneous `req_last` and cap on the same word: a single release, with no double pointer advance.
- Reset: state=IDLE, `rr_ptr=0`, `grant_id=0`, `beat_cnt=0`, timeout counter=0. Hence `busy=0`, `fifo_wr_en=0`, `req_ready=0`, `fifo_wr_data=0`.
- Reset mid-burst abandons the burst immediately. The FIFO is reset on the same `rst`.

## Timing
- Arbitration costs one cycle. A request seen in IDLE at cycle t gives `busy` and `req_ready` in cycle t+1.
- The data path has zero latency. The word accepted at edge t is the word written to the FIFO at edge t.
- Gap between consecutive grants is exactly one IDLE cycle.
- Sustained throughput within a grant is 1 word/cycle while valid and `fifo_wr_vld` are both high.
- `grant_id` changes only on the IDLE->XFER edge.
- Release takes effect on the clock edge that accepts the last word.

## Configuration
- `DSI_ARB_IDLE_TIMEOUT_EN` defined:
  - In XFER, a counter increments each cycle that `req_valid[grant_id]=0` while `fifo_wr_vld=1`.
  - The counter clears on any accepted word.
  - When it reaches `IDLE_TIMEOUT`, the grant is released (IDLE, `rr_ptr` advanced) with no FIFO write in that cycle.
  - Cycles where the FIFO is full do not count.
- `DSI_ARB_IDLE_TIMEOUT_EN` undefined: no counter and no forced release; a stalled grantee holds the FIFO indefinitely.

## Test plan
- Single requester: req 0 sends 5 words 0xA0..0xA4, last on word 5, FIFO always ready → `busy` rises 1 cycle after first valid; 5 consecutive `fifo_wr_en` pulses carrying 0xA0..0xA4; `busy` falls; `rr_ptr` = 1.
- Round-robin: all 4 requesters assert continuously, 2-word bursts → `grant_id` order 0,1,2,3,0; each grant separated by one IDLE cycle; 8 words per rotation.
- Burst cap: `BURST_LEN`=16, req 2 streams 40 words with no last, other requesters idle → grants of 16, 16, 8 words; 40 words written in order; `grant_id` = 2 each time.
- Back-pressure: `fifo_wr_vld` low for 3 cycles mid-burst → `req_ready` low, no writes, `beat_cnt` frozen, grant held; resumes with the next word and no loss.
- Timeout (`DSI_ARB_IDLE_TIMEOUT_EN`, `IDLE_TIMEOUT`=8): req 1 granted, sends 2 words then drops valid while req 3 waits → grant releases after 8 stall cycles and req 3 is granted. Without the macro, req 1 holds the grant.
- Reset mid-burst: `rst` pulse during word 3 of 6 → next cycle `busy=0`, `fifo_wr_en=0`, `rr_ptr=0`; the next request from req 0 is granted.

Source files
------------

// File: rtl/dsi_fifo_wr_arb.sv
// dsi_fifo_wr_arb: round-robin write-port arbiter in front of the DSI prefetch FIFO.
// Optional feature macro: DSI_ARB_IDLE_TIMEOUT_EN (forced release of a stalled grant).
module dsi_fifo_wr_arb #(
    parameter int N_REQ        = 4,
    parameter int DATA_W       = 32,
    parameter int BURST_LEN    = 16,
    parameter int IDLE_TIMEOUT = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*DATA_W-1:0]    req_data,
    input  logic [N_REQ-1:0]           req_last,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       fifo_wr_en,
    output logic [DATA_W-1:0]          fifo_wr_data,
    input  logic                       fifo_wr_vld,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       busy
);

    localparam int GW = $clog2(N_REQ);
    localparam int CW = $clog2(BURST_LEN + 1);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [GW-1:0]     rr_ptr;
    logic [GW-1:0]     rr_nxt;
    logic [GW-1:0]     grant_nxt;
    logic [GW-1:0]     pick;
    logic [GW-1:0]     next_ptr;
    logic [CW-1:0]     beat_cnt;
    logic [CW-1:0]     beat_nxt;
    logic [N_REQ-1:0]  g_sel;
    logic              g_valid;
    logic              g_last;
    logic [DATA_W-1:0] g_data;
    logic              accept;
    logic              at_cap;
    logic              tmo_hit;
    int                off;
    int                best;

    // First requesting index at or after rr_ptr, wrapping (smallest offset wins)
    always_comb begin
        pick = rr_ptr;
        best = N_REQ;
        off  = 0;
        for (int i = 0; i < N_REQ; i++) begin
            off = (i + N_REQ - int'(rr_ptr)) % N_REQ;
            if (req_valid[i] && (off < best)) begin
                best = off;
                pick = GW'(i);
            end
        end
    end

    // Select the current grantee's stream signals
    always_comb begin
        g_sel   = '0;
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_id == GW'(i)) begin
                g_sel[i] = 1'b1;
                g_valid  = req_valid[i];
                g_last   = req_last[i];
                g_data   = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign next_ptr = (grant_id == GW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
    assign accept   = (state == XFER) & g_valid & fifo_wr_vld;
    // Word being accepted now brings the count to BURST_LEN
    assign at_cap   = (beat_cnt == CW'(BURST_LEN - 1));
    assign busy     = (state == XFER);

`ifdef DSI_ARB_IDLE_TIMEOUT_EN
    logic [7:0] tmo_cnt;
    logic       stall;

    assign stall   = (state == XFER) & ~g_valid & fifo_wr_vld;
    assign tmo_hit = stall & (tmo_cnt == 8'(IDLE_TIMEOUT - 1));

    // Count grantee stall cycles; FIFO-full cycles neither count nor clear
    always_ff @(posedge clk) begin
        if (rst || (state != XFER) || accept || tmo_hit) begin
            tmo_cnt <= '0;
        end else if (stall) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    logic unused_tmo;

    assign tmo_hit    = 1'b0;
    assign unused_tmo = (IDLE_TIMEOUT > 0);
`endif

    // Next-state, grant bookkeeping and write-port outputs
    always_comb begin
        state_nxt    = state;
        rr_nxt       = rr_ptr;
        grant_nxt    = grant_id;
        beat_nxt     = beat_cnt;
        req_ready    = '0;
        fifo_wr_en   = 1'b0;
        fifo_wr_data = '0;
        unique case (state)
            IDLE: begin
                if (|req_valid) begin
                    state_nxt = XFER;
                    grant_nxt = pick;
                    beat_nxt  = '0;
                end
            end
            XFER: begin
                req_ready    = g_sel & {N_REQ{fifo_wr_vld}};
                fifo_wr_en   = accept;
                fifo_wr_data = g_data;
                if (accept) begin
                    beat_nxt = beat_cnt + 1'b1;
                    if (g_last || at_cap) begin
                        state_nxt = IDLE;
                        rr_nxt    = next_ptr;
                    end
                end else if (tmo_hit) begin
                    state_nxt = IDLE;
                    rr_nxt    = next_ptr;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and arbitration registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_nxt;
            grant_id <= grant_nxt;
            beat_cnt <= beat_nxt;
        end
    end

endmodule

// File: tb/tb_dsi_fifo_wr_arb.sv
// tb_dsi_fifo_wr_arb: directed bench for the DSI FIFO write arbiter.
// Build with DSI_ARB_IDLE_TIMEOUT_EN to exercise the forced-release variant.
module tb_dsi_fifo_wr_arb;

    localparam int N = 4;
`ifdef DSI_ARB_IDLE_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [127:0] req_data;
    logic [3:0]   req_last;
    logic [3:0]   req_ready;
    logic         fifo_wr_en;
    logic [31:0]  fifo_wr_data;
    logic         fifo_wr_vld;
    logic [1:0]   grant_id;
    logic         busy;

    int npass = 0;
    int ntot  = 0;
    int wi[4];
    int lim[4];
    logic [3:0] want;
    int burst_n;
    int base;
    int expw;
    bit eb;
    bit ee;
    int g;
    int w;

    always #5 clk = ~clk;

    dsi_fifo_wr_arb #(
        .N_REQ(4),
        .DATA_W(32),
        .BURST_LEN(16),
        .IDLE_TIMEOUT(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_last(req_last),
        .req_ready(req_ready),
        .fifo_wr_en(fifo_wr_en),
        .fifo_wr_data(fifo_wr_data),
        .fifo_wr_vld(fifo_wr_vld),
        .grant_id(grant_id),
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Requester i offers base + i*256 + word index; last every burst_n words
    task automatic set_inputs();
        for (int i = 0; i < N; i++) begin
            req_valid[i] = want[i] && (wi[i] < lim[i]);
            req_data[i*32 +: 32] = 32'(base + i * 256 + wi[i]);
            req_last[i] = (burst_n > 0) && (((wi[i] + 1) % burst_n) == 0);
        end
    endtask

    task automatic setup(input logic [3:0] wnt, input int l,
                         input int bn, input int b);
        want    = wnt;
        burst_n = bn;
        base    = b;
        expw    = 0;
        for (int i = 0; i < N; i++) begin
            wi[i]  = 0;
            lim[i] = l;
        end
        set_inputs();
    endtask

    task automatic tick();
        logic [3:0] a;
        a = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (a[i]) wi[i]++;
        end
        set_inputs();
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        want = '0;
        set_inputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst         = 1'b1;
        fifo_wr_vld = 1'b1;
        setup(4'b0000, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_en", fifo_wr_en, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_data", fifo_wr_data, 0);
        chk("rst_grant", grant_id, 0);
        rst = 1'b0;

        // single requester, 5-word burst A0..A4
        setup(4'b0001, 5, 5, 'hA0);
        for (int c = 0; c <= 6; c++) begin
            #1;
            eb = (c >= 1) && (c <= 5);
            chk("single_busy", busy, eb);
            chk("single_en", fifo_wr_en, eb);
            if (eb) chk("single_data", fifo_wr_data, 'hA0 + c - 1);
            tick();
        end

        // rr_ptr now 1: req1 wins over req0
        setup(4'b0011, 1, 1, 0);
        tick();
        #1;
        chk("rr_grant", grant_id, 1);
        chk("rr_data", fifo_wr_data, 'h100);
        do_reset();

        // all four requesters, 2-word bursts
        setup(4'b1111, 1000, 2, 0);
        for (int c = 0; c <= 14; c++) begin
            #1;
            eb = (c % 3) != 0;
            chk("rr4_busy", busy, eb);
            chk("rr4_en", fifo_wr_en, eb);
            if (eb) begin
                g = (c / 3) % 4;
                w = 2 * ((c / 3) / 4) + (c % 3) - 1;
                chk("rr4_grant", grant_id, g);
                chk("rr4_data", fifo_wr_data, g * 256 + w);
            end
            tick();
        end
        do_reset();

        // burst cap: req2 streams 40 words, no last
        setup(4'b0100, 40, 0, 0);
        for (int c = 0; c <= 42; c++) begin
            #1;
            eb = !((c == 0) || (c == 17) || (c == 34));
            chk("cap_busy", busy, eb);
            chk("cap_en", fifo_wr_en, eb);
            if (eb) chk("cap_grant", grant_id, 2);
            if (fifo_wr_en) begin
                chk("cap_data", fifo_wr_data, 'h200 + expw);
                expw++;
            end
            tick();
        end
        chk("cap_words", expw, 40);
        do_reset();

        // back-pressure: FIFO full for 3 cycles mid-burst
        setup(4'b0010, 6, 6, 0);
        for (int c = 0; c <= 10; c++) begin
            fifo_wr_vld = !((c >= 3) && (c <= 5));
            #1;
            eb = (c >= 1) && (c <= 9);
            ee = ((c >= 1) && (c <= 2)) || ((c >= 6) && (c <= 9));
            chk("bp_busy", busy, eb);
            chk("bp_en", fifo_wr_en, ee);
            chk("bp_ready", req_ready, (eb && fifo_wr_vld) ? 4'b0010 : 4'b0000);
            if (!fifo_wr_vld) chk("bp_beat", dut.beat_cnt, 2);
            if (ee) begin
                chk("bp_data", fifo_wr_data, 'h100 + expw);
                expw++;
            end
            tick();
        end
        fifo_wr_vld = 1'b1;
        chk("bp_words", expw, 6);
        do_reset();

        // stalled grantee: req1 sends 2 words then drops, req3 waits
        setup(4'b1010, 2, 0, 0);
        lim[3] = 1000;
        set_inputs();
        for (int c = 0; c <= 12; c++) begin
            #1;
            eb = TMO ? ((c != 0) && (c != 11)) : (c != 0);
            chk("tmo_busy", busy, eb);
            if (eb) chk("tmo_grant", grant_id, (TMO && c == 12) ? 3 : 1);
            chk("tmo_en", fifo_wr_en, (c == 1) || (c == 2) || (TMO && c == 12));
            tick();
        end
        do_reset();

        // reset mid-burst: move rr_ptr to 2, then abort req2 on word 3
        setup(4'b0010, 1, 1, 0);
        tick();
        #1;
        chk("mid_pre_en", fifo_wr_en, 1);
        tick();
        setup(4'b0100, 6, 6, 0);
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("mid_word3", fifo_wr_data, 'h202);
        tick();
        rst = 1'b0;
        #1;
        chk("mid_busy", busy, 0);
        chk("mid_en", fifo_wr_en, 0);
        chk("mid_ready", req_ready, 0);
        setup(4'b0101, 1, 1, 0);
        tick();
        #1;
        chk("mid_grant", grant_id, 0);
        chk("mid_busy2", busy, 1);
        chk("mid_data", fifo_wr_data, 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
